// File: rtl/disp_upsample_2d_pkg.sv
// Shared types and helpers for the disparity up-sampler.
// disp_scale_sat implements the disparity rescaling used when
// DISP_UPSAMPLE_SCALE_EN is defined.
package disp_pkg;

    localparam int unsigned DISP_DATA_W = 16;

    typedef logic [DISP_DATA_W-1:0] disp_conf_t;

    // Counter width able to hold 0..n-1 (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    // Left-shift the low 'bits' field by 'shift', saturate it to all-ones,
    // and pass every bit above the field through unchanged.
    function automatic logic [63:0] disp_scale_sat(input logic [63:0] word,
                                                   input int unsigned shift,
                                                   input int unsigned bits);
        logic [63:0] mask;
        logic [63:0] scaled;
        mask   = (64'd1 << bits) - 64'd1;
        scaled = (word & mask) << shift;
        if (scaled > mask) scaled = mask;
        return (word & ~mask) | scaled;
    endfunction

endpackage

// File: rtl/disp_upsample_2d_line_buf.sv
// One-row line buffer: simple dual-port RAM, one write port and one
// registered read port (1-cycle latency), written to infer block RAM.
module upsample_line_buf
    import disp_pkg::*;
#(
    parameter int unsigned data_width = DISP_DATA_W,
    parameter int unsigned depth      = 120,
    parameter int unsigned addr_w     = cnt_w(depth)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [addr_w-1:0]     wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [addr_w-1:0]     rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem [depth];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; data holds until the next read
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/disp_upsample_2d.sv
// Nearest-neighbour 2D up-sampler for the decimated disparity/confidence
// stream. Each pixel is emitted dec_factor times; each row is emitted
// dec_factor times, replayed from a one-row line buffer so the input is
// consumed exactly once.
// Optional: DISP_UPSAMPLE_SCALE_EN scales the disparity field by dec_factor
// (saturating) before output and line-buffer write.
module disp_upsample_2d
    import disp_pkg::*;
#(
    parameter int unsigned data_width = DISP_DATA_W,
    parameter int unsigned dec_factor = 2,
    parameter int unsigned in_width   = 120,
    parameter int unsigned in_height  = 240,
    parameter int unsigned disp_bits  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned COL_W = cnt_w(in_width);
    localparam int unsigned REP_W = cnt_w(dec_factor);
    localparam int unsigned ROW_W = cnt_w(in_height);

`ifdef DISP_UPSAMPLE_SCALE_EN
    localparam int unsigned SCALE_SHIFT = $clog2(dec_factor);
`else
    localparam int unsigned SCALE_SHIFT = 0;
`endif

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    logic [0:0]            state;
    logic [COL_W-1:0]      col;
    logic [REP_W-1:0]      hrep;
    logic [REP_W-1:0]      vrep;
    logic [ROW_W-1:0]      row;

    logic [data_width-1:0] fill_word;
    logic [data_width-1:0] lb_rd_data;
    logic [COL_W-1:0]      lb_rd_addr;
    logic                  lb_rd_en;
    logic                  advance;
    logic                  load;
    logic                  in_acc;
    logic                  hrep_end;
    logic                  col_end;
    logic                  vrep_end;
    logic                  row_end;
    logic                  last_word;

    // With SCALE_SHIFT == 0 this is an exact copy of in_data
    assign fill_word = data_width'(disp_scale_sat(64'(in_data), SCALE_SHIFT, disp_bits));

    assign hrep_end  = (hrep == REP_W'(dec_factor - 1));
    assign col_end   = (col  == COL_W'(in_width - 1));
    assign vrep_end  = (vrep == REP_W'(dec_factor - 1));
    assign row_end   = (row  == ROW_W'(in_height - 1));
    assign last_word = row_end && vrep_end && col_end && hrep_end;

    // Counters describe the next word to be loaded into the output register
    assign advance  = !out_valid || out_ready;
    assign in_ready = !reset && advance && (state == ST_FILL) && (hrep == '0);
    assign in_acc   = in_ready && in_valid;
    assign load     = !reset && advance &&
                      ((state == ST_REPLAY) || (hrep != '0) || in_valid);

    // Prefetch the next column on the last repeat so the word is waiting in
    // the RAM output register when the following new-pixel load happens.
    assign lb_rd_en   = load && hrep_end;
    assign lb_rd_addr = col_end ? '0 : col + COL_W'(1);

    upsample_line_buf #(
        .data_width (data_width),
        .depth      (in_width),
        .addr_w     (COL_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (in_acc),
        .wr_addr (col),
        .wr_data (fill_word),
        .rd_en   (lb_rd_en),
        .rd_addr (lb_rd_addr),
        .rd_data (lb_rd_data)
    );

    // Position counters and FILL/REPLAY state, advancing once per load
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
            col   <= '0;
            hrep  <= '0;
            vrep  <= '0;
            row   <= '0;
        end else if (load) begin
            if (!hrep_end) begin
                hrep <= hrep + REP_W'(1);
            end else begin
                hrep <= '0;
                if (!col_end) begin
                    col <= col + COL_W'(1);
                end else begin
                    col <= '0;
                    if (vrep_end) begin
                        vrep  <= '0;
                        state <= ST_FILL;
                        row   <= row_end ? '0 : row + ROW_W'(1);
                    end else begin
                        vrep  <= vrep + REP_W'(1);
                        state <= ST_REPLAY;
                    end
                end
            end
        end
    end

    // Output register; repeats keep out_data and only re-assert out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= last_word;
            if (hrep == '0) begin
                out_data <= (state == ST_FILL) ? fill_word : lb_rd_data;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_upsample_2d.sv
// Directed bench for disp_upsample_2d with a 4x2 input frame, factor 2.
module tb_disp_upsample_2d;

    localparam int DW    = 16;
    localparam int DEC   = 2;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DB    = 5;
    localparam int FRAME = W * H * DEC * DEC;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_upsample_2d #(
        .data_width (DW),
        .dec_factor (DEC),
        .in_width   (W),
        .in_height  (H),
        .disp_bits  (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tb_scale(input int v);
`ifdef DISP_UPSAMPLE_SCALE_EN
        int d;
        d = (v & 31) * 2;
        if (d > 31) d = 31;
        return (v & ~31) | d;
`else
        return v;
`endif
    endfunction

    // Output word k of a frame whose inputs are base..base+7:
    // output rows 0,1 replicate input row 0, rows 2,3 replicate input row 1.
    function automatic logic [31:0] exp_word(input int base, input int k);
        return 32'(tb_scale(base + (k / 16) * W + (k % 8) / 2));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    // mode 0: always ready; mode 1: out_ready toggles; mode 2: input gap
    task automatic run_frame(input int base, input int mode, input int nwords, input string tag);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = 0;
        int p;
        logic prev_stall = 1'b0;
        logic [DW-1:0] held = '0;
        while (out_idx < nwords && cyc < 300) begin
            @(negedge clk);
            out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (in_idx < W * H && !(mode == 2 && cyc >= 3 && cyc < 8)) begin
                in_valid = 1'b1;
                in_data  = DW'(base + in_idx);
            end else begin
                in_valid = 1'b0;
                in_data  = 16'hBEEF;
            end
            #1;
            if (prev_stall) begin
                check({tag, "_hold_data"}, out_data, held);
                check({tag, "_hold_valid"}, out_valid, 1);
            end
            p = out_idx + (out_valid ? 1 : 0);
            check({tag, "_in_ready"}, in_ready,
                  ((!out_valid || out_ready) && (p % 2 == 0) && ((p % 16) < 8)) ? 1 : 0);
            if (out_valid && out_ready) begin
                check($sformatf("%s_data[%0d]", tag, out_idx), out_data, exp_word(base, out_idx));
                check($sformatf("%s_last[%0d]", tag, out_idx), out_last, (out_idx == FRAME - 1) ? 1 : 0);
                out_idx++;
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
            if (in_valid && in_ready) in_idx++;
            cyc++;
        end
        check({tag, "_word_count"}, out_idx, nwords);
        if (nwords == FRAME && mode == 0) check({tag, "_cycles"}, cyc, 33);
        if (nwords == FRAME && mode == 2) check({tag, "_cycles"}, cyc, 37);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        do_reset();

        run_frame(1, 0, FRAME, "f1");
        run_frame(1, 1, FRAME, "bp");
        run_frame(1, 2, FRAME, "gap");
        run_frame(1, 0, 10, "part");
        do_reset();
        run_frame(11, 0, FRAME, "rst");

`ifdef DISP_UPSAMPLE_SCALE_EN
        begin
            logic [DW-1:0] vin  [3];
            logic [DW-1:0] vexp [3];
            vin[0] = 16'h0105; vexp[0] = 16'h010A;
            vin[1] = 16'h001F; vexp[1] = 16'h001F;
            vin[2] = 16'h0010; vexp[2] = 16'h001F;
            for (int i = 0; i < 3; i++) begin
                do_reset();
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = vin[i];
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                check($sformatf("scale[%0d]", i), out_data, vexp[i]);
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
